l1_victim_buffer: RTL and testbench
===================================

Name: l1_victim_buffer

Overview:
- Write-back victim buffer between the L1 icache/dcache arbiter and L2.
- Absorbs dirty-line evictions from the arbiter in one cycle, so L1 refills need not wait on slow L2 writes.
- Serves arbiter reads that hit a buffered line without touching L2.
- Drains buffered lines to L2 in FIFO order whenever the arbiter is idle.

Parameters:
- DEPTH, 4, number of cache-line entries (power of two, at least 2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- l1_address  in  16  line address from the arbiter; bits [3:0] are ignored.
- l1_wdata  in  128  eviction line data (lc3b_cache_line).
- l1_read  in  1  line read request, held until l1_resp.
- l1_write  in  1  line write (eviction) request, held until l1_resp.
- l1_resp  out  1  single-cycle response to the arbiter.
- l1_rdata  out  128  read data, valid while l1_resp is high.
- l2_address  out  16  L2 line address, [3:0]=0.
- l2_wdata  out  128  L2 write data.
- l2_read  out  1  L2 read request.
- l2_write  out  1  L2 write request.
- l2_rdata  in  128  L2 read data.
- l2_mem_resp  in  1  L2 completion, single cycle.
- buf_empty  out  1  count==0.
- buf_full  out  1  count==DEPTH.

Behaviour:
- Storage: DEPTH entries, each {valid, tag[15:4], line[127:0]}, organised as a circular FIFO.
  - head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Hit: l1_address[15:4] equals the tag of a valid entry. At most one entry can ever match.
- Reset (async, rst_n=0):
  - All valid bits, head, tail and count cleared; FSM goes to IDLE.
  - l1_resp, l2_read and l2_write are 0; l1_rdata, l2_address and l2_wdata are 0.
  - buf_empty=1, buf_full=0.
  - Reset mid-transaction drops any L2 handshake and discards buffered data.
- FSM states: IDLE, READ_L2, DRAIN, RESP.
- IDLE priority, evaluated each cycle:
  1. l1_read hit: latch the entry line into the response register, go to RESP.
  2. l1_read miss: go to READ_L2.
  3. l1_write hit: overwrite that entry's line in place (count unchanged), go to RESP.
  4. l1_write miss, not full: write the line at tail, tail+1, count+1, go to RESP.
  5. l1_write miss, full: go to DRAIN. The write is re-evaluated on return to IDLE.
  6. No request and count>0: go to DRAIN.
  7. Otherwise stay in IDLE.
- READ_L2:
  - l2_read=1 and l2_address={l1_address[15:4],4'h0}, held until l2_mem_resp.
  - On l2_mem_resp, register l2_rdata and go to RESP.
- DRAIN:
  - l2_write=1, l2_address={head tag,4'h0}, l2_wdata=head line, all held constant.
  - On l2_mem_resp, clear the head entry's valid bit, head+1, count-1, go to IDLE.
  - A drain is never aborted. L1 requests arriving during DRAIN wait in the arbiter; they are not sampled until IDLE.
- RESP: l1_resp=1 for exactly one cycle. l1_rdata = registered line (reads only; don't-care for writes). Then go to IDLE.
- Latency:
  - Buffer read hit and write accept: l1_resp 2 cycles after the request is first seen in IDLE.
  - Read miss: l1_resp 1 cycle after l2_mem_resp.
- l2_read and l2_write are never high together. Both are registered FSM decodes.
- Pointer wrap: after DEPTH allocations tail returns to 0; buf_full is taken from count, not from pointer equality.
- Coherence: a read sees the newest write to its line, because a buffered line always wins over L2 and a hit is checked before going to L2.
- Simultaneous l1_read and l1_write (arbiter violation): the read is served and the write waits.
- buf_empty and buf_full are combinational from count.

Test Plan:
- Reset then idle: rst_n low 3 cycles, no requests.
  - Required: buf_empty=1, all outputs 0, no l2_read/l2_write for 20 cycles.
- Write accept and drain: write 0x1230 with line 0xAAAA…; no further requests; L2 responds 4 cycles after l2_write.
  - Required: l1_resp 2 cycles after the request; then DRAIN with l2_address=0x1230 and l2_wdata=0xAAAA…; buf_empty=1 after l2_mem_resp.
- Read hit bypass: write 0x4000 with line D1, then immediately read 0x4008 with the L2 model stalled.
  - Required: l1_rdata=D1 with l1_resp; l2_read never asserted.
- Write hit merge: write 0x5000 with D1, then write 0x5004 with D2, before any drain.
  - Required: count stays 1; drain writes D2 to 0x5000.
- Full stall and wrap: DEPTH=4; write 0x1000, 0x1010, 0x1020, 0x1030 back-to-back with L2 stalled; then write 0x1040.
  - Required: buf_full=1 and no l1_resp for 0x1040 until the first drain (0x1000) gets l2_mem_resp.
  - Required: 0x1040 is stored in slot 0 (wrap); drain order is 0x1010, 0x1020, 0x1030, 0x1040.
- Read miss and reset mid-drain:
  - Read 0x2000 with L2 returning 0x5555… → l2_read held until l2_mem_resp, then l1_rdata=0x5555… one cycle later.
  - Assert rst_n=0 during a DRAIN → l2_write drops immediately; buf_empty=1.

Source files
------------

// File: rtl/l1_victim_buffer.sv
// Write-back victim buffer between the L1 arbiter and L2. Absorbs dirty-line
// evictions, serves read hits directly, and drains lines to L2 in FIFO order.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | sample arbiter requests, start a drain when nothing is pending
// READ_L2 | read miss forwarded to L2, waiting for l2_mem_resp
// DRAIN   | head entry being written to L2, never aborted
// RESP    | one-cycle l1_resp pulse back to the arbiter
module l1_victim_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  l1_address,
  input  logic [127:0] l1_wdata,
  input  logic         l1_read,
  input  logic         l1_write,
  output logic         l1_resp,
  output logic [127:0] l1_rdata,
  output logic [15:0]  l2_address,
  output logic [127:0] l2_wdata,
  output logic         l2_read,
  output logic         l2_write,
  input  logic [127:0] l2_rdata,
  input  logic         l2_mem_resp,
  output logic         buf_empty,
  output logic         buf_full
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, READ_L2, DRAIN, RESP} state_t;

  state_t         state;
  logic [DEPTH-1:0] valid;
  logic [11:0]    tags  [DEPTH];
  logic [127:0]   lines [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [PW:0]    count;

  logic [11:0]    req_tag;
  logic           hit;
  logic [PW-1:0]  hit_idx;
  logic           addr_unused;

  assign req_tag     = l1_address[15:4];
  assign addr_unused = ^l1_address[3:0];

  assign buf_empty = (count == '0);
  assign buf_full  = (count == (PW+1)'(DEPTH));

  // Tags are unique among valid entries, so at most one match is possible.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (tags[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      l1_resp    <= 1'b0;
      l1_rdata   <= '0;
      l2_address <= '0;
      l2_wdata   <= '0;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tags[i]  <= '0;
        lines[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (l1_read && hit) begin
            l1_rdata <= lines[hit_idx];
            l1_resp  <= 1'b1;
            state    <= RESP;
          end else if (l1_read) begin
            l2_read    <= 1'b1;
            l2_address <= {req_tag, 4'h0};
            state      <= READ_L2;
          end else if (l1_write && hit) begin
            lines[hit_idx] <= l1_wdata;
            l1_resp        <= 1'b1;
            state          <= RESP;
          end else if (l1_write && !buf_full) begin
            valid[tail] <= 1'b1;
            tags[tail]  <= req_tag;
            lines[tail] <= l1_wdata;
            tail        <= tail + 1'b1;
            count       <= count + 1'b1;
            l1_resp     <= 1'b1;
            state       <= RESP;
          end else if (l1_write || !buf_empty) begin
            // A write blocked on a full buffer is retried once this drain completes.
            l2_write   <= 1'b1;
            l2_address <= {tags[head], 4'h0};
            l2_wdata   <= lines[head];
            state      <= DRAIN;
          end
        end
        READ_L2: begin
          if (l2_mem_resp) begin
            l1_rdata <= l2_rdata;
            l2_read  <= 1'b0;
            l1_resp  <= 1'b1;
            state    <= RESP;
          end
        end
        DRAIN: begin
          if (l2_mem_resp) begin
            valid[head] <= 1'b0;
            head        <= head + 1'b1;
            count       <= count - 1'b1;
            l2_write    <= 1'b0;
            state       <= IDLE;
          end
        end
        RESP: begin
          l1_resp <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_victim_buffer.sv
// Scoreboard bench for l1_victim_buffer: directed requests push expected L1
// responses and L2 transfers into queues; a negedge monitor pops and compares.
module tb_l1_victim_buffer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  l1_address;
  logic [127:0] l1_wdata;
  logic         l1_read;
  logic         l1_write;
  logic         l1_resp;
  logic [127:0] l1_rdata;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic         l2_read;
  logic         l2_write;
  logic [127:0] l2_rdata;
  logic         l2_mem_resp;
  logic         buf_empty;
  logic         buf_full;

  always #5 clk = ~clk;

  l1_victim_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .l1_address(l1_address), .l1_wdata(l1_wdata),
    .l1_read(l1_read), .l1_write(l1_write),
    .l1_resp(l1_resp), .l1_rdata(l1_rdata),
    .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_read(l2_read), .l2_write(l2_write),
    .l2_rdata(l2_rdata), .l2_mem_resp(l2_mem_resp),
    .buf_empty(buf_empty), .buf_full(buf_full)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { bit is_read; logic [127:0] data; } l1_exp_t;
  typedef struct { logic [15:0] addr; logic [127:0] data; } l2w_exp_t;
  l1_exp_t   l1_q[$];
  l2w_exp_t  l2w_q[$];
  logic [15:0] l2r_q[$];

  bit           l2_stall = 1'b0;
  int           l2_lat   = 4;
  logic [127:0] l2_rdval = '0;
  bit           l2rd_seen = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // L2 model: answers a held request after l2_lat cycles unless stalled.
  initial begin
    int cnt;
    cnt = 0;
    l2_mem_resp = 1'b0;
    l2_rdata = '0;
    forever begin
      @(posedge clk); #1;
      l2_mem_resp = 1'b0;
      l2_rdata = l2_rdval;
      if (!l2_stall && rst_n && (l2_read || l2_write)) begin
        if (cnt >= l2_lat - 1) begin
          l2_mem_resp = 1'b1;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Monitor: pops expectations whenever the DUT completes a transfer.
  initial begin
    logic prev_rd, prev_resp;
    l1_exp_t e1;
    l2w_exp_t e2;
    logic [15:0] ea;
    prev_rd = 1'b0;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (l2_read || l2_write) chk("l2_rd_wr_exclusive", l2_read & l2_write, 0);
        if (l2_read) l2rd_seen = 1'b1;
        if (prev_rd && !prev_resp) chk("l2_read_held", l2_read, 1);
        if (l2_mem_resp && l2_write) begin
          if (l2w_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL l2_write_unexpected: got write to %h expected none", l2_address);
          end else begin
            e2 = l2w_q.pop_front();
            chk("l2_drain_addr", l2_address, e2.addr);
            chk("l2_drain_data", l2_wdata, e2.data);
          end
        end
        if (l2_mem_resp && l2_read) begin
          if (l2r_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL l2_read_unexpected: got read of %h expected none", l2_address);
          end else begin
            ea = l2r_q.pop_front();
            chk("l2_read_addr", l2_address, ea);
          end
        end
        if (l1_resp) begin
          if (l1_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL l1_resp_unexpected: got l1_resp expected none");
          end else begin
            e1 = l1_q.pop_front();
            if (e1.is_read) chk("l1_rdata", l1_rdata, e1.data);
          end
        end
        prev_rd = l2_read;
        prev_resp = l2_mem_resp;
      end else begin
        prev_rd = 1'b0;
        prev_resp = 1'b0;
      end
    end
  end

  task automatic req_start(input bit wr, input logic [15:0] a, input logic [127:0] d);
    @(posedge clk); #1;
    l1_address = a;
    l1_wdata   = d;
    l1_read    = !wr;
    l1_write   = wr;
  endtask

  // Counts negedges until l1_resp; after_l2rd reports an L2 read completion on the previous one.
  task automatic wait_resp(input string name, input int budget, output int lat, output bit after_l2rd);
    bit prev;
    prev = 1'b0;
    lat = 0;
    after_l2rd = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (l1_resp) begin
        after_l2rd = prev;
        break;
      end
      prev = l2_mem_resp && l2_read;
      if (lat >= budget) begin
        n_tests++; n_fail++;
        $display("FAIL %s_timeout: got no l1_resp in %0d cycles expected l1_resp", name, budget);
        lat = -1;
        break;
      end
    end
    l1_read  = 1'b0;
    l1_write = 1'b0;
  endtask

  task automatic l1_req(input bit wr, input logic [15:0] a, input logic [127:0] d,
                        input string name, output int lat, output bit after_l2rd);
    l1_exp_t e;
    e.is_read = !wr;
    e.data = d;
    l1_q.push_back(e);
    req_start(wr, a, d);
    wait_resp(name, 60, lat, after_l2rd);
  endtask

  task automatic wait_empty(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (buf_empty && !l2_write) break;
    end
    chk(name, buf_empty, 1);
  endtask

  task automatic push_l2w(input logic [15:0] a, input logic [127:0] d);
    l2w_exp_t e;
    e.addr = a;
    e.data = d;
    l2w_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d_a, d1, d2, d3, d5;
    logic [127:0] wl [5];
    int lat;
    bit aft;
    bit act;

    d_a = {8{16'hAAAA}};
    d1  = 128'h0123_4567_89AB_CDEF_1111_2222_3333_4444;
    d2  = 128'hFEDC_BA98_7654_3210_5555_6666_7777_8888;
    d3  = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
    d5  = {8{16'h5555}};
    for (int i = 0; i < 5; i++) wl[i] = {4{32'h1000_0000 + 32'(i)}};

    l1_address = '0; l1_wdata = '0; l1_read = 1'b0; l1_write = 1'b0;

    // reset then idle
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_buf_empty", buf_empty, 1);
    chk("rst_buf_full", buf_full, 0);
    chk("rst_l1_resp", l1_resp, 0);
    chk("rst_l2_read", l2_read, 0);
    chk("rst_l2_write", l2_write, 0);
    chk("rst_l1_rdata", l1_rdata, 0);
    chk("rst_l2_address", l2_address, 0);
    chk("rst_l2_wdata", l2_wdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    act = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (l2_read || l2_write || l1_resp) act = 1'b1;
    end
    chk("idle_no_activity", act, 0);

    // write accept and drain
    push_l2w(16'h1230, d_a);
    l1_req(1'b1, 16'h1230, d_a, "wr_accept", lat, aft);
    chk("wr_accept_latency", lat, 2);
    wait_empty("wr_drain_empty", 40);

    // read hit bypass with L2 stalled
    l2_stall = 1'b1;
    l2rd_seen = 1'b0;
    l1_req(1'b1, 16'h4000, d1, "hit_wr", lat, aft);
    chk("hit_wr_latency", lat, 2);
    l1_req(1'b0, 16'h4008, d1, "hit_rd", lat, aft);
    chk("hit_rd_latency", lat, 2);
    chk("hit_no_l2_read", l2rd_seen, 0);
    push_l2w(16'h4000, d1);
    l2_stall = 1'b0;
    wait_empty("hit_drain_empty", 40);

    // write hit merge
    l2_stall = 1'b1;
    l1_req(1'b1, 16'h5000, d1, "merge_wr1", lat, aft);
    l1_req(1'b1, 16'h5004, d2, "merge_wr2", lat, aft);
    chk("merge_latency", lat, 2);
    chk("merge_not_full", buf_full, 0);
    push_l2w(16'h5000, d2);
    l2_stall = 1'b0;
    wait_empty("merge_drain_empty", 40);

    // full stall and pointer wrap
    l2_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      l1_req(1'b1, 16'h1000 + 16'(i * 16), wl[i], "fill_wr", lat, aft);
      chk("fill_latency", lat, 2);
    end
    chk("full_flag_set", buf_full, 1);
    for (int i = 0; i < 5; i++) push_l2w(16'h1000 + 16'(i * 16), wl[i]);
    begin
      l1_exp_t e;
      e.is_read = 1'b0;
      e.data = wl[4];
      l1_q.push_back(e);
    end
    req_start(1'b1, 16'h1040, wl[4]);
    act = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (l1_resp) act = 1'b1;
    end
    chk("full_no_resp", act, 0);
    chk("full_flag_held", buf_full, 1);
    chk("full_drain_write", l2_write, 1);
    chk("full_drain_addr", l2_address, 16'h1000);
    l2_stall = 1'b0;
    wait_resp("full_retry", 60, lat, aft);
    wait_empty("wrap_drain_empty", 200);

    // read miss through L2
    l2_rdval = d5;
    l2r_q.push_back(16'h2000);
    l1_req(1'b0, 16'h2000, d5, "miss_rd", lat, aft);
    chk("miss_resp_after_l2", aft, 1);

    // reset in the middle of a drain
    l2_stall = 1'b1;
    l1_req(1'b1, 16'h3000, d3, "pre_rst_wr", lat, aft);
    for (int i = 0; i < 10; i++) begin
      if (l2_write) break;
      @(negedge clk);
    end
    chk("pre_rst_drain", l2_write, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_l2_write_drop", l2_write, 0);
    chk("rst_mid_empty", buf_empty, 1);
    chk("rst_mid_l2_address", l2_address, 0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    l2_stall = 1'b0;
    act = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (l2_write || l2_read || l1_resp) act = 1'b1;
    end
    chk("rst_discard_no_activity", act, 0);

    chk("l1_queue_drained", l1_q.size(), 0);
    chk("l2w_queue_drained", l2w_q.size(), 0);
    chk("l2r_queue_drained", l2r_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
